// File: rtl/dct_ctrl_pkg.sv
// Shared types and helpers for the DCT systolic array sequencer.
package dct_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        SETTLE,
        DRAIN,
        DONE
    } state_e;

    localparam int N_DEFAULT = 8;

    // Width of a k/row index; a 1-bit index is kept even for degenerate sizes.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Number of FEED cycles needed to stream all skewed operands.
    function automatic int feed_len(input int n);
        return 2 * n - 1;
    endfunction

    localparam int FEED_LEN = feed_len(N_DEFAULT);

endpackage

// File: rtl/dct_skew_gen.sv
// Combinational operand-index skew for the systolic array.
// Row i of the west buffer is delayed by i cycles so that PE(i,j) sees
// C[i][k] at t=i+k, matching the one-row-per-cycle ripple of north data.
module dct_skew_gen
    import dct_ctrl_pkg::*;
#(
    parameter int N  = 8,
    parameter int KW = idx_w(N)
) (
    input  logic            en_i,
    input  logic [KW:0]     t_i,
    output logic            north_vld_o,
    output logic [KW-1:0]   north_k_o,
    output logic [N-1:0]    west_vld_o,
    output logic [N*KW-1:0] west_k_o
);

    logic [KW:0] diff;

    // Map time index t to gated north/west operand indices.
    always_comb begin
        north_vld_o = 1'b0;
        north_k_o   = '0;
        west_vld_o  = '0;
        west_k_o    = '0;
        diff        = '0;
        if (en_i && (t_i < (KW+1)'(N))) begin
            north_vld_o = 1'b1;
            north_k_o   = t_i[KW-1:0];
        end
        for (int i = 0; i < N; i++) begin
            diff = t_i - (KW+1)'(i);
            if (en_i && (t_i >= (KW+1)'(i)) && (diff < (KW+1)'(N))) begin
                west_vld_o[i]           = 1'b1;
                west_k_o[i*KW +: KW]    = diff[KW-1:0];
            end
        end
    end

endmodule

// File: rtl/dct_array_ctrl.sv
// Sequencer for the N x N output-stationary DCT MAC array (Y = C*X).
// Clears the PEs, streams skewed operand indices, then drains result rows
// over a valid/ready handshake. Define DCT_2PASS_EN to run a second
// CLEAR/FEED/SETTLE/DRAIN pass (pass=1) before DONE.
module dct_array_ctrl
    import dct_ctrl_pkg::*;
#(
    parameter int N  = 8,
    parameter int KW = idx_w(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            array_clr,
    output logic            north_vld,
    output logic [KW-1:0]   north_k,
    output logic [N-1:0]    west_vld,
    output logic [N*KW-1:0] west_k,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [KW-1:0]   res_row,
    output logic            pass
);

    localparam logic [KW:0]   T_LAST = (KW+1)'(feed_len(N) - 1);
    localparam logic [KW-1:0] R_LAST = KW'(N - 1);

    state_e          state_q, state_d;
    logic [KW:0]     t_q, t_d;
    logic [KW-1:0]   r_q, r_d;
    logic            pass_q, pass_d;

    logic            busy_d, done_d, array_clr_d, res_valid_d;
    logic [KW-1:0]   res_row_d;
    logic            north_vld_d;
    logic [KW-1:0]   north_k_d;
    logic [N-1:0]    west_vld_d;
    logic [N*KW-1:0] west_k_d;

    // Next-state logic: sequencing, time index t, drain row r and pass.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        r_d     = r_q;
        pass_d  = pass_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                    t_d     = '0;
                    r_d     = '0;
                    pass_d  = 1'b0;
                end
            end
            CLEAR: begin
                state_d = FEED;
                t_d     = '0;
            end
            FEED: begin
                if (t_q == T_LAST) begin
                    state_d = SETTLE;
                    t_d     = '0;
                end else begin
                    t_d = t_q + (KW+1)'(1);
                end
            end
            SETTLE: begin
                state_d = DRAIN;
                r_d     = '0;
            end
            DRAIN: begin
                if (res_valid && res_ready) begin
                    if (r_q == R_LAST) begin
                        r_d = '0;
`ifdef DCT_2PASS_EN
                        if (!pass_q) begin
                            state_d = CLEAR;
                            pass_d  = 1'b1;
                        end else begin
                            state_d = DONE;
                            pass_d  = 1'b0;
                        end
`else
                        state_d = DONE;
                        pass_d  = 1'b0;
`endif
                    end else begin
                        r_d = r_q + KW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    dct_skew_gen #(
        .N  (N),
        .KW (KW)
    ) u_skew (
        .en_i        (state_d == FEED),
        .t_i         (t_d),
        .north_vld_o (north_vld_d),
        .north_k_o   (north_k_d),
        .west_vld_o  (west_vld_d),
        .west_k_o    (west_k_d)
    );

    // Output decode from the upcoming state so every output is a register.
    always_comb begin
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        array_clr_d = (state_d == CLEAR);
        res_valid_d = (state_d == DRAIN);
        res_row_d   = (state_d == DRAIN) ? r_d : '0;
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            t_q     <= '0;
            r_q     <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            r_q     <= r_d;
            pass_q  <= pass_d;
        end
    end

    // Registered outputs; the PEs are held cleared while in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            array_clr <= 1'b1;
            north_vld <= 1'b0;
            north_k   <= '0;
            west_vld  <= '0;
            west_k    <= '0;
            res_valid <= 1'b0;
            res_row   <= '0;
            pass      <= 1'b0;
        end else begin
            busy      <= busy_d;
            done      <= done_d;
            array_clr <= array_clr_d;
            north_vld <= north_vld_d;
            north_k   <= north_k_d;
            west_vld  <= west_vld_d;
            west_k    <= west_k_d;
            res_valid <= res_valid_d;
            res_row   <= res_row_d;
            pass      <= pass_d;
        end
    end

endmodule

// File: tb/tb_dct_array_ctrl.sv
// Self-checking bench for dct_array_ctrl (N=8); honours DCT_2PASS_EN.
module tb_dct_array_ctrl;

    localparam int N  = 8;
    localparam int KW = 3;
`ifdef DCT_2PASS_EN
    localparam int NPASS = 2;
`else
    localparam int NPASS = 1;
`endif

    logic            clk;
    logic            rst;
    logic            start;
    logic            busy;
    logic            done;
    logic            array_clr;
    logic            north_vld;
    logic [KW-1:0]   north_k;
    logic [N-1:0]    west_vld;
    logic [N*KW-1:0] west_k;
    logic            res_valid;
    logic            res_ready;
    logic [KW-1:0]   res_row;
    logic            pass;

    dct_array_ctrl #(.N(N), .KW(KW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .array_clr (array_clr),
        .north_vld (north_vld),
        .north_k   (north_k),
        .west_vld  (west_vld),
        .west_k    (west_k),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_row   (res_row),
        .pass      (pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic            busy;
        logic            done;
        logic            clr;
        logic            nv;
        logic [KW-1:0]   nk;
        logic [N-1:0]    wv;
        logic [N*KW-1:0] wk;
        logic            rv;
        logic [KW-1:0]   rr;
        logic            ps;
    } obs_t;

    typedef struct {
        int stall;
        bit start_in_feed;
        int exp_done_cyc;
        int exp_beats;
    } scn_t;

    obs_t sb[$];
    int   n_cmp;
    int   n_bad;

    function automatic obs_t observe();
        obs_t a;
        a = {busy, done, array_clr, north_vld, north_k, west_vld, west_k,
             res_valid, res_row, pass};
        return a;
    endfunction

    // Expected outputs in cycle c of a run started in cycle 0, with
    // res_ready dropped for 'stall' cycles while row 2 of pass 0 is shown.
    function automatic obs_t exp_at(int c, int stall);
        obs_t e;
        int   x, p, len0, curlen, t, d, s;
        e = '0;
        if (c <= 0) return e;
        len0 = 3*N + 1 + stall;
        x = c - 1;
        p = 0;
        if (NPASS == 2 && x >= len0) begin
            x = x - len0;
            p = 1;
        end
        curlen = (p == 0) ? len0 : 3*N + 1;
        if (x < curlen) begin
            e.busy = 1'b1;
            e.ps   = (p == 1);
            if (x == 0) begin
                e.clr = 1'b1;
            end else if (x <= 2*N - 1) begin
                t = x - 1;
                if (t < N) begin
                    e.nv = 1'b1;
                    e.nk = KW'(t);
                end
                for (int i = 0; i < N; i++) begin
                    if (t >= i && t < i + N) begin
                        e.wv[i]          = 1'b1;
                        e.wk[i*KW +: KW] = KW'(t - i);
                    end
                end
            end else if (x > 2*N) begin
                d = x - 2*N - 1;
                s = (p == 0) ? stall : 0;
                e.rv = 1'b1;
                if (d < 2)          e.rr = KW'(d);
                else if (d < 2 + s) e.rr = KW'(2);
                else                e.rr = KW'(d - s);
            end
        end else if (x == curlen) begin
            e.busy = 1'b1;
            e.done = 1'b1;
        end
        return e;
    endfunction

    function automatic logic ready_at(int c, int stall);
        int d;
        d = c - (2*N + 2);
        return (stall > 0 && d >= 2 && d < 2 + stall) ? 1'b0 : 1'b1;
    endfunction

    task automatic compare(string name, int cyc, obs_t act, obs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic compare_int(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Entered just after a clock edge with the DUT in IDLE; cycle 0 begins.
    task automatic run_scn(input int stall, input bit sf, input int ncyc,
                           output int done_cyc, output int beats);
        obs_t e;
        done_cyc = -1;
        beats    = 0;
        for (int c = 0; c < ncyc; c++) begin
            start     = (c == 0) || (sf && c >= 3 && c <= 8);
            res_ready = ready_at(c, stall);
            sb.push_back(exp_at(c, stall));
            @(negedge clk);
            e = sb.pop_front();
            compare("cycle", c, observe(), e);
            if (done && done_cyc < 0) done_cyc = c;
            if (res_valid && res_ready) beats++;
            @(posedge clk);
            #1;
        end
        start     = 1'b0;
        res_ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        scn_t scn[3];
        obs_t rst_obs;
        int   dc, bt;

        n_cmp = 0;
        n_bad = 0;
`ifdef DCT_2PASS_EN
        scn[0] = '{stall: 0, start_in_feed: 1'b0, exp_done_cyc: 51, exp_beats: 16};
        scn[1] = '{stall: 3, start_in_feed: 1'b0, exp_done_cyc: 54, exp_beats: 16};
        scn[2] = '{stall: 0, start_in_feed: 1'b1, exp_done_cyc: 51, exp_beats: 16};
`else
        scn[0] = '{stall: 0, start_in_feed: 1'b0, exp_done_cyc: 26, exp_beats: 8};
        scn[1] = '{stall: 3, start_in_feed: 1'b0, exp_done_cyc: 29, exp_beats: 8};
        scn[2] = '{stall: 0, start_in_feed: 1'b1, exp_done_cyc: 26, exp_beats: 8};
`endif
        rst_obs     = '0;
        rst_obs.clr = 1'b1;

        rst       = 1'b0;
        start     = 1'b0;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        compare("reset_values", 0, observe(), rst_obs);
        rst = 1'b1;
        @(posedge clk);
        #1;
        compare("after_release", 0, observe(), obs_t'('0));

        for (int k = 0; k < 3; k++) begin
            run_scn(scn[k].stall, scn[k].start_in_feed, 60, dc, bt);
            compare_int($sformatf("done_cycle_scn%0d", k), dc, scn[k].exp_done_cyc);
            compare_int($sformatf("beats_scn%0d", k), bt, scn[k].exp_beats);
        end

        // Reset mid-FEED: async return to reset values, no done.
        run_scn(0, 1'b0, 6, dc, bt);
        rst = 1'b0;
        #1;
        compare("async_reset", 6, observe(), rst_obs);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            compare("held_reset", 7 + c, observe(), rst_obs);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        compare("after_midrun_release", 0, observe(), obs_t'('0));
        run_scn(0, 1'b0, 60, dc, bt);
        compare_int("done_cycle_after_reset", dc, scn[0].exp_done_cyc);
        compare_int("beats_after_reset", bt, scn[0].exp_beats);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dct_array_ctrl.md
Name: dct_array_ctrl

Overview:
- Sequencer for the N×N output-stationary systolic MAC array that computes the DCT matrix product Y = C·X.
- Clears the PE accumulators and generates skewed, zero-gated operand indices for the coefficient (west) and data (north) buffers.
- Drains the finished accumulator rows to a downstream consumer through a valid/ready handshake.
- Sits between the frame-level start/done interface and the array plus its operand ROM/RAM.

Parameters:
- N, 8: array dimension and dot-product length K; power of two, 2..16.
- KW, $clog2(N): width of a k/row index.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  run request; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of run.
- array_clr  out  1  synchronous active-high clear to all PEs.
- north_vld  out  1  north operand lanes enabled, all columns; gate lanes to 0 when low.
- north_k  out  KW  data row index k for all north lanes.
- west_vld  out  N  per-row west operand enable; gate row to 0 when low.
- west_k  out  N*KW  per-row coefficient column index, packed, row i at [i*KW +: KW].
- res_valid  out  1  accumulator row res_row is presented.
- res_ready  in  1  consumer accepts the row.
- res_row  out  KW  array row selected for output.
- pass  out  1  current pass; 0 unless DCT_2PASS_EN.

Behaviour:
- Reset (rst=0, async): state IDLE, t=0. Outputs: busy=0, done=0, north_vld=0, west_vld=0, north_k=0, west_k=0, res_valid=0, res_row=0, pass=0, array_clr=1. array_clr drops to 0 on the first clock after release.
- All outputs are registered.
- States: IDLE -> CLEAR -> FEED -> SETTLE -> DRAIN -> DONE -> IDLE.
- IDLE: start=1 -> CLEAR.
- CLEAR: one cycle; array_clr=1, t cleared.
- FEED: t counts 0..2N-2 (2N-1 cycles), then -> SETTLE.
  - north_vld=1 and north_k=t while t<N; else 0/0.
  - west_vld[i]=1 and west_k[i]=t-i while i<=t<i+N; else 0/0.
  - North operands ripple one row per cycle through the PEs, so PE(i,j) meets C[i][k] and X[k][j] together at t=i+k.
- SETTLE: one cycle; all operands gated to 0, so accumulators hold because the product is 0.
- DRAIN: res_valid=1, res_row=r with r starting at 0.
  - r advances only on res_valid&&res_ready.
  - While res_ready=0, res_row holds and the accumulators hold because operands stay at 0.
  - After the beat accepted at r=N-1 -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- Latency (cycle 0 = IDLE cycle with start=1): CLEAR in cycle 1, FEED in cycles 2..2N, SETTLE in 2N+1, first res_valid in 2N+2. For N=8, res_valid first asserts at cycle 18.
- start while busy=1 is ignored and not queued. start held high through DONE begins a new run from the IDLE cycle that follows.
- done and res_valid are never high together.
- Reset asserted mid-run: immediate return to the reset values above. A partial DRAIN is discarded with no done.
- The index counter t is KW+1 bits wide. The value 2N-1 is never reached in FEED.

Optional Feature:
- Macro DCT_2PASS_EN.
- Defined: after the DRAIN of pass 0 the block goes to CLEAR with pass=1 and repeats FEED/SETTLE/DRAIN; the downstream wrapper swaps operand sources on pass. DONE is reached only after pass 1 drains, and done pulses once per run. pass returns to 0 in DONE.
- Undefined: single pass, pass tied to 0.

Decomposition:
- Package dct_ctrl_pkg: state enum (IDLE, CLEAR, FEED, SETTLE, DRAIN, DONE), constants FEED_LEN=2N-1 and the KW width function.
- One sub-module, dct_skew_gen: combinational mapping from t to west_vld/west_k and north_vld/north_k, registered by the parent.

Test Plan:
- Reset with rst=0: array_clr=1 and all other outputs 0. One cycle after release: array_clr=0, state IDLE.
- N=8, start pulse at cycle 0, res_ready=1:
  - array_clr=1 in cycle 1.
  - west_vld[3]=1 in cycles 5..12, with west_k[3]=0..7.
  - north_vld=1 in cycles 2..9.
  - res_valid in cycles 18..25, res_row=0..7; done at 26; busy low at 27.
- Backpressure: hold res_ready=0 for 3 cycles while res_row=2. res_row stays 2, res_valid stays 1, no operand enables assert, and done is delayed by 3 cycles.
- start=1 during FEED: no effect, cycle counts identical to the base run.
- rst=0 at cycle 6 (mid-FEED): outputs reach reset values asynchronously, no done. A new start after release gives nominal timing.
- With DCT_2PASS_EN: pass=0 during the first drain and 1 during the second; 16 res_valid beats in total; a single done at cycle 2×(2N+1+N)+1 = 51 for N=8 with res_ready=1.
